// File: rtl/ravil_memory_pkg.sv
// ravil_memory_pkg
// Shared definitions for the receive frame buffer: the upstream receiver
// state encoding, the CRC-32 residue a clean frame leaves behind, and the
// default buffer depth and frame length limits.
package ravil_memory_pkg;

  // Upstream receiver states as presented on iFSM_state.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_END      = 3'd3,
    ST_ERROR    = 3'd4
  } rx_state_t;

  // Value left in the running CRC-32 register once the FCS has been
  // clocked through along with the payload.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // Defaults: 2048-byte buffer, Ethernet frame length limits (FCS included).
  localparam int DEF_DEPTH_LOG2 = 11;
  localparam int DEF_MIN_LEN    = 64;
  localparam int DEF_MAX_LEN    = 1518;

endpackage

// File: rtl/ravil_mem_dpram.sv
// ravil_mem_dpram
// Byte-wide dual-port frame buffer, 2**pADDR_W deep. Contents are never
// reset; only the control logic decides which bytes count as committed.
// Ports:
//   iclk     - clock, rising edge
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write byte
//   rd_addr  - read address (downstream reader)
//   rd_data  - read byte, registered (one clock read latency)
module ravil_mem_dpram
  import ravil_memory_pkg::*;
#(
  parameter int pADDR_W = DEF_DEPTH_LOG2
) (
  input  logic               iclk,
  input  logic               we,
  input  logic [pADDR_W-1:0] wr_addr,
  input  logic [7:0]         wr_data,
  input  logic [pADDR_W-1:0] rd_addr,
  output logic [7:0]         rd_data
);

  logic [7:0] mem [2**pADDR_W];

  always_ff @(posedge iclk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ravil_memory.sv
// ravil_memory
// Receive-side frame store. Bytes of each incoming frame are written into a
// circular buffer as they arrive; when the frame ends it is either committed
// (length and frame count published, commit pointer advanced) or rejected
// (write pointer rolled back so the bytes are silently reused).
// Ports:
//   iclk       - clock, rising edge
//   i_rst      - asynchronous reset, active low
//   idv        - byte valid from the upstream receiver
//   i_error    - receive error flag
//   i_crc      - running CRC-32 register of the upstream receiver
//   irx_d      - received byte
//   iFSM_state - upstream receiver state (see rx_state_t)
//   o_FIFO     - byte length of the last committed frame
//   o_reg      - number of committed frames, modulo 256
module ravil_memory
  import ravil_memory_pkg::*;
#(
  parameter int pDEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int pMIN_LEN    = DEF_MIN_LEN,
  parameter int pMAX_LEN    = DEF_MAX_LEN
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  input  logic                   idv,
  input  logic                   i_error,
  input  logic [31:0]            i_crc,
  input  logic [7:0]             irx_d,
  input  logic [2:0]             iFSM_state,
  output logic [pDEPTH_LOG2-1:0] o_FIFO,
  output logic [7:0]             o_reg
);

  localparam int AW = pDEPTH_LOG2;
  localparam logic [AW-1:0] LEN_SAT = '1;
  localparam logic [AW-1:0] MIN_LEN = AW'(pMIN_LEN);
  localparam logic [AW-1:0] MAX_LEN = AW'(pMAX_LEN);

  rx_state_t     rx_state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] commit_ptr;
  logic [AW-1:0] frame_len;
  logic          err_seen;
  logic          in_frame;
  logic          armed;
  logic          prev_dv;
  logic [7:0]    rd_data_unused;

  logic data_byte;
  logic frame_start;
  logic frame_byte;
  logic store_byte;
  logic frame_end;
  logic err_now;
  logic frame_good;

  assign rx_state = rx_state_t'(iFSM_state);

  // A DATA byte only belongs to a frame if we are already inside one or we
  // saw the receiver pass through IDLE/PREAMBLE (armed). This is what keeps
  // the tail of a frame interrupted by reset from being stored.
  assign data_byte   = idv && (rx_state == ST_DATA);
  assign frame_start = data_byte && armed && !in_frame;
  assign frame_byte  = data_byte && (in_frame || armed);

  // Bytes past the maximum length are counted but not stored, so an
  // oversized frame cannot run the write pointer round into committed data.
  assign store_byte  = frame_byte && (frame_len < MAX_LEN);

  assign frame_end   = !idv && prev_dv && in_frame && (frame_len != '0);
  assign err_now     = i_error || (rx_state == ST_ERROR);
  assign frame_good  = !err_seen && !err_now && (i_crc == CRC_RESIDUE) &&
                       (frame_len >= MIN_LEN) && (frame_len <= MAX_LEN);

  // Pointer and frame checker state. The commit/rollback decision is taken
  // on the edge that sees idv low, so the outputs change one clock after idv
  // falls and a frame starting on the very next cycle uses the new pointer.
  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      frame_len  <= '0;
      err_seen   <= 1'b0;
      in_frame   <= 1'b0;
      armed      <= 1'b0;
      prev_dv    <= 1'b0;
      o_FIFO     <= '0;
      o_reg      <= '0;
    end else begin
      prev_dv <= idv;
      if ((rx_state == ST_IDLE) || (rx_state == ST_PREAMBLE)) begin
        armed <= 1'b1;
      end
      if (frame_end) begin
        in_frame  <= 1'b0;
        frame_len <= '0;
        err_seen  <= 1'b0;
        armed     <= 1'b1;
        if (frame_good) begin
          commit_ptr <= wr_ptr;
          o_FIFO     <= frame_len;
          o_reg      <= o_reg + 8'd1;
        end else begin
          wr_ptr <= commit_ptr;
        end
      end else if (frame_byte) begin
        in_frame <= 1'b1;
        armed    <= 1'b0;
        if (frame_len != LEN_SAT) begin
          frame_len <= frame_len + AW'(1);
        end
        err_seen <= frame_start ? err_now : (err_seen || err_now);
        if (store_byte) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end else if (in_frame) begin
        err_seen <= err_seen || err_now;
      end
    end
  end

  ravil_mem_dpram #(
    .pADDR_W(AW)
  ) u_mem (
    .iclk    (iclk),
    .we      (store_byte),
    .wr_addr (wr_ptr),
    .wr_data (irx_d),
    .rd_addr (commit_ptr),
    .rd_data (rd_data_unused)
  );

endmodule

// File: tb/tb_ravil_memory.sv
// tb_ravil_memory
// Bench for ravil_memory. Frames are generated as byte lists with a chosen
// length, FCS outcome, error pulse and optional mid-frame reset; a small
// model decides from the frame rules alone whether each frame is kept, and
// tracks the expected committed pointer, last length and frame count.
module tb_ravil_memory;

  localparam int          DEPTH   = 2048;
  localparam int          MIN_LEN = 64;
  localparam int          MAX_LEN = 1518;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;
  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_PRE   = 3'd1;
  localparam logic [2:0]  S_DATA  = 3'd2;
  localparam logic [2:0]  S_END   = 3'd3;

  logic        iclk = 1'b0;
  logic        i_rst = 1'b0;
  logic        idv = 1'b0;
  logic        i_error = 1'b0;
  logic [31:0] i_crc = '0;
  logic [7:0]  irx_d = '0;
  logic [2:0]  iFSM_state = S_IDLE;
  logic [10:0] o_FIFO;
  logic [7:0]  o_reg;

  int errors = 0;
  int checks = 0;
  int exp_fifo = 0;
  int exp_reg = 0;
  int model_ptr = 0;
  bit check_en = 1'b0;

  ravil_memory #(
    .pDEPTH_LOG2 (11),
    .pMIN_LEN    (MIN_LEN),
    .pMAX_LEN    (MAX_LEN)
  ) dut (
    .iclk       (iclk),
    .i_rst      (i_rst),
    .idv        (idv),
    .i_error    (i_error),
    .i_crc      (i_crc),
    .irx_d      (irx_d),
    .iFSM_state (iFSM_state),
    .o_FIFO     (o_FIFO),
    .o_reg      (o_reg)
  );

  always #5 iclk = ~iclk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Outputs are compared with the model on every falling edge.
  always @(negedge iclk) begin
    if (check_en) begin
      checkOutput("o_FIFO", 32'(o_FIFO), exp_fifo);
      checkOutput("o_reg", 32'(o_reg), exp_reg);
    end
  end

  // Hold reset for a number of cycles; the model forgets everything.
  task automatic resetPulse(input int cycles);
    i_rst = 1'b0;
    idv = 1'b0;
    i_error = 1'b0;
    iFSM_state = S_IDLE;
    exp_fifo = 0;
    exp_reg = 0;
    model_ptr = 0;
    repeat (cycles) begin
      @(posedge iclk);
      #1;
    end
    i_rst = 1'b1;
  endtask

  // Send one frame. err_at/rst_at are byte indices (-1 for none); gap is the
  // number of IDLE cycles before the frame (0 = starts right after the
  // previous end cycle, no preamble).
  task automatic applyStimulus(input int len, input bit crc_ok, input int err_at,
                               input int rst_at, input int gap);
    logic [7:0]  bytes_q[$];
    logic [10:0] addr;
    bit          discarded = 1'b0;
    bit          good;
    for (int g = 0; g < gap; g++) begin
      idv = 1'b0;
      i_error = 1'b0;
      iFSM_state = S_IDLE;
      @(posedge iclk);
      #1;
    end
    if (gap > 0) begin
      iFSM_state = S_PRE;
      @(posedge iclk);
      #1;
    end
    for (int i = 0; i < len; i++) begin
      irx_d = 8'($urandom);
      bytes_q.push_back(irx_d);
      idv = 1'b1;
      iFSM_state = S_DATA;
      i_error = (i == err_at);
      i_crc = $urandom;
      if (i == rst_at) begin
        i_rst = 1'b0;
        exp_fifo = 0;
        exp_reg = 0;
        model_ptr = 0;
        discarded = 1'b1;
        #1;
        checkOutput("o_FIFO_async_reset", 32'(o_FIFO), 0);
        checkOutput("o_reg_async_reset", 32'(o_reg), 0);
      end
      if (rst_at >= 0 && i == rst_at + 10) begin
        i_rst = 1'b1;
      end
      @(posedge iclk);
      #1;
    end
    idv = 1'b0;
    i_error = 1'b0;
    iFSM_state = S_END;
    i_crc = crc_ok ? RESIDUE : (RESIDUE ^ (32'd1 << $urandom_range(31, 0)));
    @(posedge iclk);
    #1;
    iFSM_state = S_IDLE;
    good = !discarded && crc_ok && (err_at < 0) && (len >= MIN_LEN) && (len <= MAX_LEN);
    if (good) begin
      for (int i = 0; i < len; i++) begin
        addr = 11'((model_ptr + i) % DEPTH);
        checkOutput("buffer_byte", 32'(dut.u_mem.mem[addr]), 32'(bytes_q[i]));
      end
      model_ptr = (model_ptr + len) % DEPTH;
      exp_fifo = len;
      exp_reg = (exp_reg + 1) % 256;
    end
    checkOutput("wr_ptr", 32'(dut.wr_ptr), model_ptr);
  endtask

  initial begin
    int len;
    int err_at;
    i_rst = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    check_en = 1'b1;
    checkOutput("reset_o_FIFO", 32'(o_FIFO), 0);
    checkOutput("reset_o_reg", 32'(o_reg), 0);
    checkOutput("reset_wr_ptr", 32'(dut.wr_ptr), 0);
    i_rst = 1'b1;

    // Good 64-byte frame lands at address 0.
    applyStimulus(64, 1'b1, -1, -1, 3);
    checkOutput("first_frame_len", 32'(o_FIFO), 64);
    checkOutput("first_frame_count", 32'(o_reg), 1);

    // Bad FCS: nothing published, pointer back to 64.
    applyStimulus(64, 1'b0, -1, -1, 2);
    checkOutput("bad_fcs_wr_ptr", 32'(dut.wr_ptr), 64);
    checkOutput("bad_fcs_count", 32'(o_reg), 1);

    // Error pulse mid-frame, then a good 100-byte frame right behind it.
    applyStimulus(64, 1'b1, 20, -1, 2);
    applyStimulus(100, 1'b1, -1, -1, 0);
    checkOutput("frame100_len", 32'(o_FIFO), 100);
    checkOutput("frame100_wr_ptr", 32'(dut.wr_ptr), 164);

    // Error on the last byte, then length limits.
    applyStimulus(80, 1'b1, 79, -1, 1);
    applyStimulus(60, 1'b1, -1, -1, 1);
    applyStimulus(1519, 1'b1, -1, -1, 1);
    checkOutput("limits_count", 32'(o_reg), 2);
    applyStimulus(64, 1'b1, -1, -1, 0);
    applyStimulus(1518, 1'b1, -1, -1, 1);
    checkOutput("max_len_accepted", 32'(o_FIFO), 1518);

    // Randomised frames.
    repeat (16) begin
      len = $urandom_range(40, 300);
      err_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      applyStimulus(len, $urandom_range(0, 3) != 0, err_at, -1, $urandom_range(0, 3));
    end

    // Reset for 10 cycles around byte 30; next good frame goes to address 0.
    applyStimulus(80, 1'b1, -1, 30, 2);
    checkOutput("after_reset_count", 32'(o_reg), 0);
    applyStimulus(64, 1'b1, -1, -1, 2);
    checkOutput("after_reset_wr_ptr", 32'(dut.wr_ptr), 64);
    checkOutput("after_reset_count1", 32'(o_reg), 1);

    // 256 back-to-back good 64-byte frames: count and pointer both wrap.
    resetPulse(2);
    for (int k = 0; k < 256; k++) begin
      applyStimulus(64, 1'b1, -1, -1, (k == 0) ? 1 : $urandom_range(0, 2));
    end
    checkOutput("wrap_count", 32'(o_reg), 0);
    checkOutput("wrap_len", 32'(o_FIFO), 64);
    checkOutput("wrap_wr_ptr", 32'(dut.wr_ptr), 0);

    repeat (2) @(posedge iclk);
    #1;
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ravil_memory.md
RAVIL_MEMORY -- requirements
Module: ravil_memory

Interface
REQ-001 SHALL have parameter pDEPTH_LOG2, default 11, meaning log2 of frame buffer depth in bytes (2048).
REQ-002 SHALL have parameter pMIN_LEN, default 64, meaning minimum accepted frame length in bytes, FCS included.
REQ-003 SHALL have parameter pMAX_LEN, default 1518, meaning maximum accepted frame length in bytes, FCS included.
REQ-004 SHALL have port iclk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port idv, input, 1 bit: byte valid from the upstream receiver.
REQ-007 SHALL have port i_error, input, 1 bit: receive error flag, sampled throughout the frame.
REQ-008 SHALL have port i_crc, input, 32 bits: running CRC-32 register of the upstream receiver.
REQ-009 SHALL have port irx_d, input, 8 bits: received byte.
REQ-010 SHALL have port iFSM_state, input, 3 bits: upstream state (0 IDLE, 1 PREAMBLE, 2 DATA, 3 END, 4 ERROR).
REQ-011 SHALL have port o_FIFO, output, 11 bits: byte length of the last committed frame.
REQ-012 SHALL have port o_reg, output, 8 bits: count of committed frames, modulo 256.

Function
REQ-013 A byte SHALL be written to buffer[wr_ptr] on every rising edge with idv=1 and iFSM_state=DATA; wr_ptr SHALL then increment, and frame_len (11 bits, saturating at 2047) SHALL also increment.
REQ-014 The buffer SHALL be circular with an 11-bit address; wr_ptr SHALL wrap from 2047 to 0.
REQ-015 An internal sticky flag err_seen SHALL set when i_error=1 or iFSM_state=ERROR on any cycle of a frame; it SHALL clear at frame start.
REQ-016 Frame start SHALL be the first DATA byte after IDLE or PREAMBLE; frame_len SHALL be 0 before that byte is counted.
REQ-017 Frame end SHALL be detected on the first cycle with idv=0 after a cycle with idv=1 and a nonzero frame_len.
REQ-018 At frame end the frame SHALL be good only if all of these hold:
  - err_seen=0 and i_error=0 on that cycle;
  - i_crc equals the residue 32'hC704DD7B;
  - pMIN_LEN <= frame_len <= pMAX_LEN.
REQ-019 On a good frame, one clock after end detection:
  - commit_ptr SHALL take wr_ptr;
  - o_FIFO SHALL take frame_len;
  - o_reg SHALL increment, wrapping from 255 to 0.
REQ-020 On a bad frame, one clock after end detection, wr_ptr SHALL roll back to commit_ptr, and o_FIFO and o_reg SHALL hold.
REQ-021 If i_error rises on the same cycle as the last data byte, that byte SHALL be written and the frame SHALL be discarded.
REQ-022 A new frame starting on the cycle right after the end cycle SHALL begin writing at the updated wr_ptr or the rolled-back pointer, with no byte lost.
REQ-023 Committed data SHALL never be overwritten by a rejected frame; frames longer than pMAX_LEN are rejected before wrap can corrupt the committed frame.

Reset
REQ-024 While i_rst=0, all of the following SHALL clear asynchronously: wr_ptr, commit_ptr, frame_len, err_seen, o_FIFO=0, o_reg=0.
REQ-025 Buffer contents SHALL NOT be reset.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release, the module SHALL wait for the next frame start.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE, PREAMBLE, DATA, END, ERROR), the CRC residue constant, and the length limits.
REQ-028 The buffer SHALL be a separate sub-module, ravil_mem_dpram: 2048x8, one synchronous write port and one read port (read port reserved for a downstream reader).
REQ-029 The control logic (pointers, checker) SHALL live in ravil_memory.

Verification
REQ-030 Scenario: 64-byte good frame with a correct FCS -> o_FIFO=64 and o_reg=1 one clock after idv falls, and buffer[0..63] holds the bytes.
REQ-031 Scenario: 64-byte frame with one corrupted FCS byte -> o_FIFO and o_reg unchanged, and wr_ptr back to its pre-frame value.
REQ-032 Scenario: good frame with i_error pulsed for one cycle mid-frame -> frame discarded, and the next good 100-byte frame is committed with o_FIFO=100 at address 64 when it follows a committed 64-byte frame.
REQ-033 Scenario: 60-byte and 1519-byte frames with correct CRC -> both rejected.
REQ-034 Scenario: i_rst=0 for 10 cycles during the byte-30 window of a frame -> outputs 0 immediately, and the following good frame is committed at address 0.
REQ-035 Scenario: 256 good 64-byte frames back to back -> o_reg wraps to 0, and wr_ptr wraps past 2047 correctly.
